// File: rtl/mac_package.sv
// Shared types for the MAC accelerator job scheduler.
// The watchdog path is enabled by defining MAC_JOB_SCHED_WATCHDOG_EN.
package mac_package;

    localparam int MAC_ADDR_W          = 32;
    localparam int MAC_LEN_W           = 16;
    localparam int MAC_JOB_SCHED_CNT_W = 32;

    typedef struct packed {
        logic [MAC_ADDR_W-1:0] a_addr;
        logic [MAC_ADDR_W-1:0] b_addr;
        logic [MAC_ADDR_W-1:0] c_addr;
        logic [MAC_ADDR_W-1:0] d_addr;
        logic [MAC_LEN_W-1:0]  len;
        logic [4:0]            shift;
        logic                  simple_mul;
    } mac_job_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RUN,
        CPL
    } sched_state_t;

endpackage

// File: rtl/mac_rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr_i, wrapping.
// Holds no state; the scheduler owns the pointer.
module mac_rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o,
    output logic             any_o
);

    logic [IW-1:0] k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            k = IW'((int'(ptr_i) + i) % N_REQ);
            if (!any_o && req_i[k]) begin
                any_o    = 1'b1;
                idx_o    = k;
                gnt_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_job_scheduler.sv
// Round-robin job scheduler sharing one MAC engine between N_REQ requesters.
// Define MAC_JOB_SCHED_WATCHDOG_EN to enable the RUN-state watchdog/abort path.
module mac_job_scheduler
    import mac_package::*;
#(
    parameter int N_REQ       = 4,
    parameter int LEN_W       = 16,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 65535,
    localparam int IW         = $clog2(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  mac_job_t [N_REQ-1:0]   req_job_i,
    output logic [N_REQ-1:0]       req_ready_o,
    output logic [N_REQ-1:0]       cpl_valid_o,
    output logic                   cpl_err_o,
    output mac_job_t               job_o,
    output logic [IW-1:0]          grant_id_o,
    output logic                   start_o,
    input  logic                   done_i,
    output logic                   abort_o,
    output logic                   busy_o
);

    if (ADDR_W != MAC_ADDR_W || LEN_W != MAC_LEN_W || N_REQ < 2 ||
        N_REQ > 16 || TIMEOUT_CYC < 2) begin : g_cfg_err
        $error("mac_job_scheduler: unsupported parameter set");
    end

    sched_state_t   state_q;
    logic [IW-1:0]  rr_q;
    mac_job_t       job_q;
    logic [IW-1:0]  gid_q;
    logic           err_q;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;

    mac_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req_i (req_valid_i),
        .ptr_i (rr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

`ifdef MAC_JOB_SCHED_WATCHDOG_EN
    logic [MAC_JOB_SCHED_CNT_W-1:0] cnt_q;
    logic                           wd_hit;

    assign wd_hit = (cnt_q == MAC_JOB_SCHED_CNT_W'(TIMEOUT_CYC - 1));
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rr_q    <= IW'(N_REQ - 1);
            job_q   <= '0;
            gid_q   <= '0;
            err_q   <= 1'b0;
`ifdef MAC_JOB_SCHED_WATCHDOG_EN
            cnt_q   <= '0;
`endif
        end else if (clear_i) begin
            // In-flight job is dropped silently; no completion, no abort.
            state_q <= IDLE;
            rr_q    <= IW'(N_REQ - 1);
            err_q   <= 1'b0;
`ifdef MAC_JOB_SCHED_WATCHDOG_EN
            cnt_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        job_q <= req_job_i[arb_idx];
                        gid_q <= arb_idx;
                        if (req_job_i[arb_idx].len == LEN_W'(0)) begin
                            err_q   <= 1'b1;
                            state_q <= CPL;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= RUN;
`ifdef MAC_JOB_SCHED_WATCHDOG_EN
                    cnt_q   <= '0;
`endif
                end
                RUN: begin
                    if (done_i) begin
                        err_q   <= 1'b0;
                        state_q <= CPL;
`ifdef MAC_JOB_SCHED_WATCHDOG_EN
                    end else if (wd_hit) begin
                        err_q   <= 1'b1;
                        state_q <= CPL;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
`endif
                    end
                end
                CPL: begin
                    rr_q    <= gid_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE && !clear_i && !rst_i) ? arb_gnt : '0;
    assign start_o     = (state_q == ISSUE);
    assign busy_o      = (state_q != IDLE);
    assign cpl_valid_o = (state_q == CPL) ? (N_REQ'(1) << gid_q) : '0;
    assign cpl_err_o   = (state_q == CPL) && err_q;
    assign job_o       = job_q;
    assign grant_id_o  = gid_q;

`ifdef MAC_JOB_SCHED_WATCHDOG_EN
    // A coincident done_i suppresses the abort.
    assign abort_o = (state_q == RUN) && wd_hit && !done_i;
`else
    assign abort_o = 1'b0;
`endif

endmodule
